// File: rtl/hours_counter_ext_if.sv
// Purpose: control and display bundle between the clock datapath and hours_counter_ext.
// Latency: none, signal bundle only.
// Backpressure: none; every input is a level or a one-cycle pulse, and there is no ready path.
// Ports: master drives milTime/hourTick/setEn/setInc/setDec/loadEn/loadHour and observes the outputs.
//        slave is the counter: it reads the controls and drives loadErr/hour24/hour/hourBcd/amPm/dayRoll/dayOfWeek.
interface hours_counter_ext_if #(
    parameter int HOUR_W = 5,
    parameter int DAY_W  = 3
);
    logic              milTime;
    logic              hourTick;
    logic              setEn;
    logic              setInc;
    logic              setDec;
    logic              loadEn;
    logic [HOUR_W-1:0] loadHour;
    logic              loadErr;
    logic [HOUR_W-1:0] hour24;
    logic [HOUR_W-1:0] hour;
    logic [7:0]        hourBcd;
    logic              amPm;
    logic              dayRoll;
    logic [DAY_W-1:0]  dayOfWeek;

    modport master (
        output milTime, hourTick, setEn, setInc, setDec, loadEn, loadHour,
        input  loadErr, hour24, hour, hourBcd, amPm, dayRoll, dayOfWeek
    );

    modport slave (
        input  milTime, hourTick, setEn, setInc, setDec, loadEn, loadHour,
        output loadErr, hour24, hour, hourBcd, amPm, dayRoll, dayOfWeek
    );
endinterface

// File: rtl/hours_counter_ext.sv
// Purpose: time-of-day hour counter with 12/24-hour BCD decode, user set/load and a day-of-week counter.
// Latency: state updates on the clkMSec edge; the display decode is combinational from the raw hour.
// Backpressure: none; a tick that arrives during set mode or a load is dropped, not queued.
// Ports: clkMSec is the clock. resetN is a synchronous active-high reset.
//        bus (slave) carries the controls (milTime, hourTick, setEn/setInc/setDec, loadEn/loadHour)
//        and the outputs (loadErr, hour24, hour, hourBcd, amPm, dayRoll, dayOfWeek).
module hours_counter_ext #(
    parameter int HOURS_PER_DAY = 24,
    parameter int HOUR_W        = 5,
    parameter int RESET_HOUR    = 0,
    parameter int DAYS_PER_WEEK = 7,
    parameter int DAY_W         = 3
) (
    input  logic clkMSec,
    input  logic resetN,
    hours_counter_ext_if.slave bus
);
    localparam int                HALF      = HOURS_PER_DAY / 2;
    localparam logic [HOUR_W-1:0] LAST_HOUR = HOUR_W'(HOURS_PER_DAY - 1);
    localparam logic [HOUR_W-1:0] HALF_HOUR = HOUR_W'(HALF);
    localparam logic [HOUR_W-1:0] RST_HOUR  = HOUR_W'(RESET_HOUR);
    localparam logic [DAY_W-1:0]  LAST_DAY  = DAY_W'(DAYS_PER_WEEK - 1);

    logic [HOUR_W-1:0] cnt;
    logic [DAY_W-1:0]  day;
    logic              dayRollQ;
    logic              loadErrQ;

    logic [HOUR_W-1:0] halfMod;
    logic [HOUR_W-1:0] dispHour;
    logic [7:0]        disp8;
    logic [7:0]        tens;
    logic [7:0]        ones;

    // One action per cycle: reset, then load, then set step, then tick.
    // Pulses default low so dayRoll/loadErr last exactly one cycle.
    always_ff @(posedge clkMSec) begin
        if (resetN) begin
            cnt      <= RST_HOUR;
            day      <= '0;
            dayRollQ <= 1'b0;
            loadErrQ <= 1'b0;
        end else begin
            dayRollQ <= 1'b0;
            loadErrQ <= 1'b0;
            if (bus.loadEn) begin
                if (bus.loadHour <= LAST_HOUR) begin
                    cnt <= bus.loadHour;
                end else begin
                    loadErrQ <= 1'b1;
                end
            end else if (bus.setEn) begin
                // Set-mode wraps are silent: no dayRoll and the day is left alone.
                // Inc and dec together cancel out.
                if (bus.setInc && !bus.setDec) begin
                    cnt <= (cnt == LAST_HOUR) ? '0 : cnt + HOUR_W'(1);
                end else if (bus.setDec && !bus.setInc) begin
                    cnt <= (cnt == '0) ? LAST_HOUR : cnt - HOUR_W'(1);
                end
            end else if (bus.hourTick) begin
                if (cnt == LAST_HOUR) begin
                    cnt      <= '0;
                    dayRollQ <= 1'b1;
                    day      <= (day == LAST_DAY) ? '0 : day + DAY_W'(1);
                end else begin
                    cnt <= cnt + HOUR_W'(1);
                end
            end
        end
    end

    // 12-hour mode shows HALF in place of 0, so midnight and noon both read as HALF.
    always_comb begin
        halfMod  = cnt % HALF_HOUR;
        dispHour = cnt;
        if (!bus.milTime) begin
            dispHour = (halfMod == '0) ? HALF_HOUR : halfMod;
        end
    end

    // The displayed hour never exceeds 98, so two BCD digits are enough.
    assign disp8 = 8'(dispHour);
    assign tens  = disp8 / 8'd10;
    assign ones  = disp8 % 8'd10;

    assign bus.hour24    = cnt;
    assign bus.hour      = dispHour;
    assign bus.hourBcd   = {tens[3:0], ones[3:0]};
    assign bus.amPm      = (cnt >= HALF_HOUR);
    assign bus.dayRoll   = dayRollQ;
    assign bus.loadErr   = loadErrQ;
    assign bus.dayOfWeek = day;
endmodule

// File: tb/tb_hours_counter_ext.sv
module tb_hours_counter_ext;
    logic clk = 1'b0;
    logic rstA = 1'b1;
    logic rstB = 1'b1;
    always #5 clk = ~clk;

    hours_counter_ext_if #(.HOUR_W(5), .DAY_W(3)) ifA ();
    hours_counter_ext_if #(.HOUR_W(4), .DAY_W(3)) ifB ();

    hours_counter_ext #(
        .HOURS_PER_DAY(24), .HOUR_W(5), .RESET_HOUR(0), .DAYS_PER_WEEK(7), .DAY_W(3)
    ) dutA (
        .clkMSec(clk), .resetN(rstA), .bus(ifA)
    );

    hours_counter_ext #(
        .HOURS_PER_DAY(10), .HOUR_W(4), .RESET_HOUR(3), .DAYS_PER_WEEK(7), .DAY_W(3)
    ) dutB (
        .clkMSec(clk), .resetN(rstB), .bus(ifB)
    );

    int nCmp = 0;
    int nErr = 0;

    // Reference state of dutA, in plain integers.
    int mCnt = 0;
    int mDay = 0;
    int mRoll = 0;
    int mErr = 0;

    function automatic int dispHour(input int c, input bit mil, input int hpd);
        int half;
        half = hpd / 2;
        if (mil) return c;
        if ((c % half) == 0) return half;
        return c % half;
    endfunction

    function automatic int toBcd(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    // Advance the reference from the inputs presented now, clock once, clear the pulses.
    task automatic stepA();
        int lh;
        lh = int'(ifA.loadHour);
        if (rstA) begin
            mCnt = 0; mDay = 0; mRoll = 0; mErr = 0;
        end else begin
            mRoll = 0; mErr = 0;
            if (ifA.loadEn) begin
                if (lh < 24) mCnt = lh;
                else mErr = 1;
            end else if (ifA.setEn) begin
                if (ifA.setInc && !ifA.setDec) mCnt = (mCnt + 1) % 24;
                else if (ifA.setDec && !ifA.setInc) mCnt = (mCnt + 23) % 24;
            end else if (ifA.hourTick) begin
                mCnt = mCnt + 1;
                if (mCnt == 24) begin
                    mCnt = 0;
                    mRoll = 1;
                    mDay = (mDay + 1) % 7;
                end
            end
        end
        @(posedge clk);
        #1;
        ifA.hourTick = 1'b0;
        ifA.setInc   = 1'b0;
        ifA.setDec   = 1'b0;
        ifA.loadEn   = 1'b0;
    endtask

    task automatic stepB();
        @(posedge clk);
        #1;
        ifB.hourTick = 1'b0;
    endtask

    task automatic test_reset();
        rstA = 1'b1;
        ifA.milTime = 1'b0;
        stepA();
        stepA();
        rstA = 1'b0;
        nCmp++; if (ifA.hour24 !== 5'd0) begin nErr++; $display("FAIL reset_hour24: got %0d want 0", ifA.hour24); end
        nCmp++; if (ifA.hour !== 5'd12) begin nErr++; $display("FAIL reset_hour12: got %0d want 12", ifA.hour); end
        nCmp++; if (ifA.amPm !== 1'b0) begin nErr++; $display("FAIL reset_ampm: got %0b want 0", ifA.amPm); end
        nCmp++; if (ifA.hourBcd !== 8'h12) begin nErr++; $display("FAIL reset_bcd12: got %h want 12", ifA.hourBcd); end
        nCmp++; if (ifA.dayOfWeek !== 3'd0) begin nErr++; $display("FAIL reset_day: got %0d want 0", ifA.dayOfWeek); end
        nCmp++; if (ifA.dayRoll !== 1'b0 || ifA.loadErr !== 1'b0) begin nErr++; $display("FAIL reset_pulses: got roll=%0b err=%0b want 0 0", ifA.dayRoll, ifA.loadErr); end
        ifA.milTime = 1'b1;
        #1;
        nCmp++; if (ifA.hour !== 5'd0) begin nErr++; $display("FAIL reset_hour24mode: got %0d want 0", ifA.hour); end
        nCmp++; if (ifA.hourBcd !== 8'h00) begin nErr++; $display("FAIL reset_bcd24: got %h want 00", ifA.hourBcd); end
        ifA.milTime = 1'b0;
        stepA();
        nCmp++; if (ifA.hour24 !== 5'd0) begin nErr++; $display("FAIL release_hold: got %0d want 0", ifA.hour24); end
    endtask

    task automatic test_ticks();
        int rolls;
        rolls = 0;
        ifA.milTime = 1'b0;
        for (int t = 1; t <= 168; t++) begin
            ifA.hourTick = 1'b1;
            stepA();
            if (ifA.dayRoll === 1'b1) rolls++;
            nCmp++;
            if (ifA.hour24 !== 5'(mCnt) || ifA.dayRoll !== 1'(mRoll) || ifA.dayOfWeek !== 3'(mDay)) begin
                nErr++;
                $display("FAIL tick_%0d: got cnt=%0d roll=%0b day=%0d want cnt=%0d roll=%0d day=%0d",
                         t, ifA.hour24, ifA.dayRoll, ifA.dayOfWeek, mCnt, mRoll, mDay);
            end
            if (t == 12) begin
                nCmp++; if (ifA.hour !== 5'd12 || ifA.amPm !== 1'b1) begin nErr++; $display("FAIL tick12_noon: got hour=%0d ampm=%0b want 12 1", ifA.hour, ifA.amPm); end
            end
            if (t == 13) begin
                nCmp++; if (ifA.hour !== 5'd1 || ifA.amPm !== 1'b1) begin nErr++; $display("FAIL tick13_1pm: got hour=%0d ampm=%0b want 1 1", ifA.hour, ifA.amPm); end
            end
            if (t == 24) begin
                nCmp++; if (ifA.hour24 !== 5'd0 || ifA.dayRoll !== 1'b1 || ifA.dayOfWeek !== 3'd1) begin
                    nErr++; $display("FAIL tick24_roll: got cnt=%0d roll=%0b day=%0d want 0 1 1", ifA.hour24, ifA.dayRoll, ifA.dayOfWeek);
                end
                stepA();
                nCmp++; if (ifA.dayRoll !== 1'b0 || ifA.hour24 !== 5'd0) begin nErr++; $display("FAIL roll_width: got roll=%0b cnt=%0d want 0 0", ifA.dayRoll, ifA.hour24); end
            end
        end
        nCmp++; if (ifA.dayOfWeek !== 3'd0 || rolls != 7) begin nErr++; $display("FAIL week_wrap: got day=%0d rolls=%0d want 0 7", ifA.dayOfWeek, rolls); end
    endtask

    task automatic test_load();
        ifA.milTime = 1'b0;
        ifA.loadEn = 1'b1; ifA.loadHour = 5'd23;
        stepA();
        nCmp++; if (ifA.hour24 !== 5'd23 || ifA.hour !== 5'd11 || ifA.amPm !== 1'b1 || ifA.hourBcd !== 8'h11 || ifA.loadErr !== 1'b0) begin
            nErr++; $display("FAIL load_23: got h24=%0d h=%0d ampm=%0b bcd=%h err=%0b want 23 11 1 11 0",
                             ifA.hour24, ifA.hour, ifA.amPm, ifA.hourBcd, ifA.loadErr);
        end
        ifA.loadEn = 1'b1; ifA.loadHour = 5'd24;
        stepA();
        nCmp++; if (ifA.loadErr !== 1'b1 || ifA.hour24 !== 5'd23) begin nErr++; $display("FAIL load_24_err: got err=%0b h24=%0d want 1 23", ifA.loadErr, ifA.hour24); end
        stepA();
        nCmp++; if (ifA.loadErr !== 1'b0) begin nErr++; $display("FAIL loaderr_width: got %0b want 0", ifA.loadErr); end
    endtask

    task automatic test_set();
        int dayBefore;
        ifA.loadEn = 1'b1; ifA.loadHour = 5'd0;
        stepA();
        dayBefore = mDay;
        ifA.setEn = 1'b1;
        ifA.setDec = 1'b1;
        stepA();
        nCmp++; if (ifA.hour24 !== 5'd23 || ifA.dayRoll !== 1'b0 || ifA.dayOfWeek !== 3'(dayBefore)) begin
            nErr++; $display("FAIL set_dec_wrap: got h24=%0d roll=%0b day=%0d want 23 0 %0d", ifA.hour24, ifA.dayRoll, ifA.dayOfWeek, dayBefore);
        end
        ifA.setInc = 1'b1; ifA.setDec = 1'b1;
        stepA();
        nCmp++; if (ifA.hour24 !== 5'd23) begin nErr++; $display("FAIL set_both: got %0d want 23", ifA.hour24); end
        ifA.hourTick = 1'b1;
        stepA();
        nCmp++; if (ifA.hour24 !== 5'd23 || ifA.dayRoll !== 1'b0) begin nErr++; $display("FAIL set_tick_drop: got h24=%0d roll=%0b want 23 0", ifA.hour24, ifA.dayRoll); end
        ifA.setInc = 1'b1;
        stepA();
        nCmp++; if (ifA.hour24 !== 5'd0 || ifA.dayRoll !== 1'b0 || ifA.dayOfWeek !== 3'(dayBefore)) begin
            nErr++; $display("FAIL set_inc_wrap: got h24=%0d roll=%0b day=%0d want 0 0 %0d", ifA.hour24, ifA.dayRoll, ifA.dayOfWeek, dayBefore);
        end
        ifA.setEn = 1'b0;
        stepA();
    endtask

    task automatic test_priority();
        int dayBefore;
        ifA.loadEn = 1'b1; ifA.loadHour = 5'd23;
        stepA();
        dayBefore = mDay;
        ifA.loadEn = 1'b1; ifA.loadHour = 5'd5; ifA.hourTick = 1'b1;
        stepA();
        nCmp++; if (ifA.hour24 !== 5'd5 || ifA.dayRoll !== 1'b0 || ifA.dayOfWeek !== 3'(dayBefore)) begin
            nErr++; $display("FAIL load_over_tick: got h24=%0d roll=%0b day=%0d want 5 0 %0d", ifA.hour24, ifA.dayRoll, ifA.dayOfWeek, dayBefore);
        end
        rstA = 1'b1;
        ifA.loadEn = 1'b1; ifA.loadHour = 5'd9; ifA.hourTick = 1'b1;
        ifA.setEn = 1'b1; ifA.setInc = 1'b1;
        stepA();
        rstA = 1'b0; ifA.setEn = 1'b0;
        nCmp++; if (ifA.hour24 !== 5'd0 || ifA.dayOfWeek !== 3'd0 || ifA.loadErr !== 1'b0) begin
            nErr++; $display("FAIL reset_over_load: got h24=%0d day=%0d err=%0b want 0 0 0", ifA.hour24, ifA.dayOfWeek, ifA.loadErr);
        end
        ifA.hourTick = 1'b1;
        stepA();
        nCmp++; if (ifA.hour24 !== 5'd1) begin nErr++; $display("FAIL resume_after_reset: got %0d want 1", ifA.hour24); end
    endtask

    task automatic test_random();
        logic [25:0] got;
        logic [25:0] want;
        int h;
        for (int i = 0; i < 600; i++) begin
            rstA = ($urandom_range(0, 99) < 2);
            ifA.loadEn   = ($urandom_range(0, 99) < 6);
            ifA.loadHour = 5'($urandom_range(0, 31));
            ifA.setEn    = ($urandom_range(0, 99) < 20);
            ifA.setInc   = $urandom_range(0, 1) == 1;
            ifA.setDec   = $urandom_range(0, 1) == 1;
            ifA.hourTick = ($urandom_range(0, 99) < 70);
            ifA.milTime  = $urandom_range(0, 1) == 1;
            stepA();
            rstA = 1'b0;
            h = dispHour(mCnt, ifA.milTime, 24);
            want = {1'(mErr), 5'(mCnt), 5'(h), 8'(toBcd(h)), 1'(mCnt >= 12), 1'(mRoll), 3'(mDay), 2'b00};
            got  = {ifA.loadErr, ifA.hour24, ifA.hour, ifA.hourBcd, ifA.amPm, ifA.dayRoll, ifA.dayOfWeek, 2'b00};
            nCmp++;
            if (got !== want) begin
                nErr++;
                $display("FAIL random_%0d: got {err,h24,h,bcd,ampm,roll,day}=%h want %h", i, got, want);
            end
        end
        ifA.setEn = 1'b0;
    endtask

    task automatic test_reparam();
        ifB.milTime = 1'b0;
        rstB = 1'b1;
        stepB();
        rstB = 1'b0;
        nCmp++; if (ifB.hour24 !== 4'd3 || ifB.hour !== 4'd3 || ifB.amPm !== 1'b0 || ifB.hourBcd !== 8'h03) begin
            nErr++; $display("FAIL b_reset: got h24=%0d h=%0d ampm=%0b bcd=%h want 3 3 0 03", ifB.hour24, ifB.hour, ifB.amPm, ifB.hourBcd);
        end
        ifB.hourTick = 1'b1; stepB();
        ifB.hourTick = 1'b1; stepB();
        nCmp++; if (ifB.hour24 !== 4'd5 || ifB.hour !== 4'd5 || ifB.amPm !== 1'b1) begin
            nErr++; $display("FAIL b_cnt5: got h24=%0d h=%0d ampm=%0b want 5 5 1", ifB.hour24, ifB.hour, ifB.amPm);
        end
        for (int k = 0; k < 4; k++) begin
            ifB.hourTick = 1'b1; stepB();
        end
        nCmp++; if (ifB.hour24 !== 4'd9 || ifB.dayRoll !== 1'b0) begin nErr++; $display("FAIL b_cnt9: got h24=%0d roll=%0b want 9 0", ifB.hour24, ifB.dayRoll); end
        ifB.hourTick = 1'b1; stepB();
        nCmp++; if (ifB.hour24 !== 4'd0 || ifB.dayRoll !== 1'b1 || ifB.dayOfWeek !== 3'd1 || ifB.hour !== 4'd5) begin
            nErr++; $display("FAIL b_wrap: got h24=%0d roll=%0b day=%0d h=%0d want 0 1 1 5", ifB.hour24, ifB.dayRoll, ifB.dayOfWeek, ifB.hour);
        end
    endtask

    initial begin
        ifA.milTime = 1'b0; ifA.hourTick = 1'b0; ifA.setEn = 1'b0; ifA.setInc = 1'b0;
        ifA.setDec = 1'b0; ifA.loadEn = 1'b0; ifA.loadHour = '0;
        ifB.milTime = 1'b0; ifB.hourTick = 1'b0; ifB.setEn = 1'b0; ifB.setInc = 1'b0;
        ifB.setDec = 1'b0; ifB.loadEn = 1'b0; ifB.loadHour = '0;
        #2;
        test_reset();
        test_ticks();
        test_load();
        test_set();
        test_priority();
        test_random();
        test_reparam();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule

// File: doc/hours_counter_ext.md
Name: hours_counter_ext

Overview:
- Parametrised time-of-day hour counter for the clock datapath, fed by the minutes stage.
- Holds raw hour state 0..HOURS_PER_DAY-1 and advances on a one-cycle hourTick from the minutes rollover.
- Decodes the state to 12-hour or 24-hour display with AM/PM and BCD digits, and supports user set/load.
- Adds a day-rollover pulse and a day-of-week counter.

Parameters:
- HOURS_PER_DAY, 24, hours per day. Must be even, 2..98.
- HOUR_W, 5, width of the binary hour outputs. Must satisfy 2^HOUR_W > HOURS_PER_DAY.
- RESET_HOUR, 0, raw hour after reset. Must be < HOURS_PER_DAY.
- DAYS_PER_WEEK, 7, day counter modulus, >= 1.
- DAY_W, 3, width of dayOfWeek. Must satisfy 2^DAY_W >= DAYS_PER_WEEK.

Ports:
- clkMSec  in  1  system clock.
- resetN  in  1  synchronous, active-high reset (1 = reset).
- milTime  in  1  1 = 24-hour display, 0 = 12-hour display.
- hourTick  in  1  single-cycle pulse: advance one hour.
- setEn  in  1  set mode. While high, hourTick is discarded.
- setInc  in  1  single-cycle pulse: raw hour +1, honoured only when setEn = 1.
- setDec  in  1  single-cycle pulse: raw hour -1, honoured only when setEn = 1.
- loadEn  in  1  load loadHour into raw hour.
- loadHour  in  HOUR_W  raw hour value to load (24-hour encoding).
- loadErr  out  1  pulse: load rejected (value out of range).
- hour24  out  HOUR_W  raw hour state.
- hour  out  HOUR_W  displayed hour.
- hourBcd  out  8  displayed hour as BCD: [7:4] tens, [3:0] ones.
- amPm  out  1  0 = AM, 1 = PM.
- dayRoll  out  1  pulse: day boundary crossed.
- dayOfWeek  out  DAY_W  day index, 0..DAYS_PER_WEEK-1.

Behaviour:
- State registers: cnt (raw hour), day, dayRoll, loadErr. All update on rising clkMSec.
- Reset (resetN = 1 at an edge): cnt = RESET_HOUR, day = 0, dayRoll = 0, loadErr = 0. Reset wins over every other input.
- Update priority, highest first, one action per cycle:
  1. reset;
  2. loadEn;
  3. setEn with exactly one of setInc/setDec asserted;
  4. hourTick with setEn = 0;
  5. hold.
- Load:
  - If loadHour < HOURS_PER_DAY: cnt = loadHour, loadErr = 0.
  - Otherwise cnt is unchanged and loadErr = 1 for one cycle.
  - Any pending hourTick or setInc/setDec in a load cycle is dropped.
- Set mode:
  - setInc wraps HOURS_PER_DAY-1 -> 0; setDec wraps 0 -> HOURS_PER_DAY-1.
  - setInc and setDec together: no change.
  - Set-mode wraps never assert dayRoll or change day.
- Tick:
  - cnt = cnt+1 when cnt < HOURS_PER_DAY-1.
  - At HOURS_PER_DAY-1: cnt = 0, dayRoll = 1 for exactly one cycle, coincident with cnt = 0, and day advances.
  - day wraps DAYS_PER_WEEK-1 -> 0.
  - Ticks arriving while setEn = 1 are lost, not queued.
- dayRoll and loadErr are 0 in every cycle other than those stated above.
- Decode (combinational from cnt, so valid in the same cycle cnt updates; zero latency after the edge). Let HALF = HOURS_PER_DAY/2.
  - amPm = (cnt >= HALF), in both display modes.
  - milTime = 1: hour = cnt.
  - milTime = 0: h = cnt mod HALF; hour = HALF if h = 0, else h. So 0 -> 12 AM and HALF -> 12 PM for the default parameters.
  - hourBcd: tens = hour/10, ones = hour mod 10. Values are always <= 98.
  - hour24 = cnt.
- Toggling milTime only changes the display outputs. cnt, amPm and day are unaffected, and no pulse is generated.
- Reset asserted mid-set or mid-load overrides that cycle completely.
- Releasing reset resumes normal counting on the next edge.

Test Plan:
- Reset then release with default parameters:
  - cnt = 0, hour = 12, amPm = 0, hourBcd = 0x12, dayOfWeek = 0, dayRoll = 0.
  - With milTime = 1, hour = 0 and hourBcd = 0x00.
- 24 hourTick pulses from 0, milTime = 0:
  - Tick 12 gives hour = 12, amPm = 1; tick 13 gives hour = 1, amPm = 1.
  - Tick 24 gives cnt = 0, dayRoll high for exactly 1 cycle, dayOfWeek = 1.
  - 168 ticks in total: dayOfWeek wraps 6 -> 0.
- loadEn with loadHour = 23 -> hour24 = 23, milTime = 0 shows hour = 11, amPm = 1, hourBcd = 0x11.
  - loadHour = 24 -> loadErr pulses 1 cycle and hour24 stays 23.
- setEn = 1, cnt = 0, setDec -> cnt = 23 with no dayRoll.
  - setInc and setDec together -> no change.
  - hourTick during setEn -> discarded, cnt unchanged.
- Simultaneous loadEn (loadHour = 5) and hourTick at cnt = 23 -> cnt = 5, dayRoll = 0, day unchanged.
  - resetN asserted in the same cycle -> cnt = RESET_HOUR.
- Re-parametrise HOURS_PER_DAY = 10, HOUR_W = 4, RESET_HOUR = 3:
  - After reset, cnt = 3, 12-hour display shows 3, amPm = 0.
  - Tick at cnt = 9 -> wrap to 0 with dayRoll.
  - cnt = 5 shows 5, amPm = 1.
